systolic_matmul_engine: RTL and testbench
=========================================

SYSTOLIC_MATMUL_ENGINE -- requirements
Module: systolic_matmul_engine

Interface
REQ-001 Parameter: N, default 4, meaning array rows = columns = input lanes.
REQ-002 Parameter: DW, default 8, meaning data/weight element width.
REQ-003 Parameter: AW, default 32, meaning accumulator and result width.
REQ-004 Parameter: KW, default 8, meaning width of the reduction-length field.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  begin a job; sampled only in IDLE.
REQ-008 k_len  input  KW  reduction length K, sampled with start.
REQ-009 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-010 in_valid  input  1  input vector present.
REQ-011 in_ready  output  1  engine accepts input vector.
REQ-012 data_in  input  N*DW  lane i = A[i][k], lane 0 at LSBs.
REQ-013 weight_in  input  N*DW  lane j = B[k][j], lane 0 at LSBs.
REQ-014 out_valid  output  1  result beat present.
REQ-015 out_ready  input  1  consumer accepts result beat.
REQ-016 out_data  output  AW  C[out_row][out_col].
REQ-017 out_row, out_col  output  clog2(N) each  index of current beat.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse at job completion.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, FLUSH, DRAIN.
REQ-021 IDLE + start: clear all N*N accumulators and skew registers; latch k_len and signed_mode; next state LOAD if k_len>0, else DRAIN.
REQ-022 start outside IDLE SHALL be ignored.
REQ-023 in_ready SHALL be 1 only in LOAD; a step occurs on each cycle with in_valid && in_ready.
REQ-024 No step without a handshake: the skew registers, inter-cell pipeline registers and accumulators hold their values.
REQ-025 Input skew: lane i of data and lane j of weight SHALL be delayed by i and j steps respectively, using internal shift registers of depth 0..N-1.
REQ-026 Propagation: data moves one column right per step; weight moves one row down per step; cell (i,j) consumes operand pair k at step k+i+j.
REQ-027 Each cell SHALL add the full-precision product (2*DW bits, sign- or zero-extended per latched signed_mode) to its accumulator; the sum wraps modulo 2^AW.
REQ-028 After K handshakes, LOAD -> FLUSH; FLUSH SHALL run exactly 2N-2 cycles, stepping every cycle with zero operands injected; then FLUSH -> DRAIN.
REQ-029 DRAIN SHALL emit N*N beats in row-major order (row 0 col 0 first); out_data/out_row/out_col SHALL be registered and held stable while out_valid && !out_ready.
REQ-030 The first out_valid SHALL rise on the cycle after entry to DRAIN; there SHALL be no bubbles between beats while out_ready = 1.
REQ-031 On the handshake of beat N*N-1: out_valid -> 0, done = 1 for that following cycle, state -> IDLE; start SHALL be accepted on the cycle after done.
REQ-032 k_len = 0 SHALL produce N*N beats of value 0.
REQ-033 in_valid and data_in SHALL be ignored outside LOAD; out_ready SHALL be ignored outside DRAIN.

Reset
REQ-034 While rst = 1: state IDLE; in_ready, out_valid, busy and done = 0; out_data, out_row, out_col = 0; all accumulators, skew and pipeline registers = 0.
REQ-035 Reset asserted mid-job SHALL abort the job immediately; no beat or done SHALL be produced for it.

Verification
REQ-036 N=4, unsigned, K=4, all A=1, all B=2, in_valid and out_ready held 1 -> 16 beats each 8, indices (0,0)..(3,3) row-major, done 1 cycle after last beat.
REQ-037 N=4, K=1, A=0xFD, B=0x02: signed_mode=1 -> every beat 0xFFFFFFFA; signed_mode=0 -> every beat 506.
REQ-038 N=4, K=4, A = identity, B[k][j] = 4k+j+1 -> C equals B (beat values 1..16 in order); repeat with random in_valid gaps and random out_ready -> identical values, no dropped or duplicated beats, out_data stable under stall.
REQ-039 k_len=0 -> busy rises, 16 beats of 0, done pulse; start pulsed during DRAIN -> ignored, beat count stays 16.
REQ-040 rst pulsed after 2 of 4 LOAD handshakes -> outputs at reset values; a new K=1 job with A=3, B=5 -> all beats 15, with no residue from the aborted job.

Source files
------------

// File: rtl/systolic_matmul_engine.sv
// Output-stationary N x N systolic matrix multiplier: streams K skewed operand vectors
// through the array, flushes the wavefront, then drains C row-major over valid/ready.
module systolic_matmul_engine #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 32,
    parameter int KW = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            signed_mode,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] data_in,
    input  logic [N*DW-1:0] weight_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_data,
    output logic [IW-1:0]   out_row,
    output logic [IW-1:0]   out_col,
    output logic            busy,
    output logic            done
);
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    localparam int FLUSH_LEN = 2*N - 2;
    localparam int FW        = $clog2(2*N);

    state_t        state, state_nx;
    logic [KW-1:0] load_cnt;
    logic [FW-1:0] flush_cnt;
    logic          sm;
    logic          accept, step, last_load, last_flush, last_beat;
    logic [IW-1:0] nx_row, nx_col;

    logic [DW-1:0] a_lane [N];
    logic [DW-1:0] b_lane [N];
    logic [DW-1:0] a_edge [N];
    logic [DW-1:0] b_edge [N];
    logic [DW-1:0] a_sk   [N][N];
    logic [DW-1:0] b_sk   [N][N];
    logic [DW-1:0] a_op   [N][N];
    logic [DW-1:0] b_op   [N][N];
    logic [DW-1:0] a_pipe [N][N];
    logic [DW-1:0] b_pipe [N][N];
    logic [AW-1:0] acc    [N][N];

    // Extending both operands to AW before multiplying gives the exact product mod 2^AW.
    function automatic logic [AW-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic s);
        logic [AW-1:0] ae, be;
        ae = {{(AW-DW){s & a[DW-1]}}, a};
        be = {{(AW-DW){s & b[DW-1]}}, b};
        return ae * be;
    endfunction

    assign accept     = (state == IDLE) && start;
    assign step       = ((state == LOAD) && in_valid) || (state == FLUSH);
    assign last_load  = (load_cnt == KW'(1));
    assign last_flush = (flush_cnt == FW'(1));
    assign last_beat  = (out_row == IW'(N-1)) && (out_col == IW'(N-1));
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = (k_len != '0) ? LOAD : DRAIN;
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && last_load) state_nx = (FLUSH_LEN == 0) ? DRAIN : FLUSH;
            end
            FLUSH: if (last_flush) state_nx = DRAIN;
            DRAIN: if (out_valid && out_ready && last_beat) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt  <= '0;
            flush_cnt <= '0;
            sm        <= 1'b0;
        end else begin
            if (accept) begin
                load_cnt <= k_len;
                sm       <= signed_mode;
            end else if ((state == LOAD) && in_valid) begin
                load_cnt <= load_cnt - KW'(1);
            end
            if ((state == LOAD) && in_valid && last_load) flush_cnt <= FW'(FLUSH_LEN);
            else if (state == FLUSH)                      flush_cnt <= flush_cnt - FW'(1);
        end
    end

    // Zeros are injected outside LOAD so the flush only drains the wavefront.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_lane[i] = (state == LOAD) ? data_in[i*DW +: DW]   : '0;
            b_lane[i] = (state == LOAD) ? weight_in[i*DW +: DW] : '0;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_edge[i] = '0;
            b_edge[i] = '0;
        end
        a_edge[0] = a_lane[0];
        b_edge[0] = b_lane[0];
        for (int i = 1; i < N; i++) begin
            a_edge[i] = a_sk[i][i];
            b_edge[i] = b_sk[i][i];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_op[i][j] = '0;
                b_op[i][j] = '0;
            end
        for (int i = 0; i < N; i++) begin
            a_op[i][0] = a_edge[i];
            for (int j = 1; j < N; j++) a_op[i][j] = a_pipe[i][j-1];
        end
        for (int j = 0; j < N; j++) begin
            b_op[0][j] = b_edge[j];
            for (int i = 1; i < N; i++) b_op[i][j] = b_pipe[i-1][j];
        end
    end

    // Lane i skew line: entry d holds the lane value from d steps ago, tapped at d = i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a_sk[i][j]   <= '0;
                    b_sk[i][j]   <= '0;
                    a_pipe[i][j] <= '0;
                    b_pipe[i][j] <= '0;
                    acc[i][j]    <= '0;
                end
        end else if (accept) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a_sk[i][j]   <= '0;
                    b_sk[i][j]   <= '0;
                    a_pipe[i][j] <= '0;
                    b_pipe[i][j] <= '0;
                    acc[i][j]    <= '0;
                end
        end else if (step) begin
            for (int i = 1; i < N; i++) begin
                a_sk[i][1] <= a_lane[i];
                b_sk[i][1] <= b_lane[i];
                for (int d = 2; d < N; d++)
                    if (d <= i) begin
                        a_sk[i][d] <= a_sk[i][d-1];
                        b_sk[i][d] <= b_sk[i][d-1];
                    end
            end
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a_pipe[i][j] <= a_op[i][j];
                    b_pipe[i][j] <= b_op[i][j];
                    acc[i][j]    <= acc[i][j] + mul_ext(a_op[i][j], b_op[i][j], sm);
                end
        end
    end

    always_comb begin
        nx_row = out_row;
        nx_col = out_col + IW'(1);
        if (out_col == IW'(N-1)) begin
            nx_col = '0;
            nx_row = out_row + IW'(1);
        end
    end

    // First cycle of DRAIN has out_valid low; it loads beat 0 from settled accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == DRAIN) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_row   <= '0;
                    out_col   <= '0;
                    out_data  <= acc[0][0];
                end else if (out_ready) begin
                    if (last_beat) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        out_row  <= nx_row;
                        out_col  <= nx_col;
                        out_data <= acc[nx_row][nx_col];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Directed + randomized bench for systolic_matmul_engine against a plain matrix-product model.
module tb_systolic_matmul_engine;
    localparam int N = 4, DW = 8, AW = 32, KW = 8, IW = 2, KMAX = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            signed_mode;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] data_in;
    logic [N*DW-1:0] weight_in;
    logic            out_valid;
    logic            out_ready;
    logic [AW-1:0]   out_data;
    logic [IW-1:0]   out_row;
    logic [IW-1:0]   out_col;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ma [N][KMAX];
    logic [DW-1:0] mb [KMAX][N];

    always #5 clk = ~clk;

    systolic_matmul_engine #(.N(N), .DW(DW), .AW(AW), .KW(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .signed_mode(signed_mode),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in), .weight_in(weight_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] ref_c(input int r, input int c, input int k, input bit sm);
        longint sum = 0;
        longint a, b;
        for (int t = 0; t < k; t++) begin
            a = longint'(ma[r][t]);
            b = longint'(mb[t][c]);
            if (sm && a >= 128) a -= 256;
            if (sm && b >= 128) b -= 256;
            sum += a * b;
        end
        return AW'(sum);
    endfunction

    task automatic fill_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
        for (int i = 0; i < N; i++)
            for (int t = 0; t < KMAX; t++) begin
                ma[i][t] = av;
                mb[t][i] = bv;
            end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++)
            for (int t = 0; t < KMAX; t++) begin
                ma[i][t] = DW'($urandom);
                mb[t][i] = DW'($urandom);
            end
    endtask

    task automatic fill_identity();
        for (int i = 0; i < N; i++)
            for (int t = 0; t < KMAX; t++) begin
                ma[i][t] = (i == t) ? DW'(1) : DW'(0);
                mb[t][i] = DW'(4*t + i + 1);
            end
    endtask

    task automatic drive_vec(input int idx, input bit v);
        for (int i = 0; i < N; i++) begin
            data_in[i*DW +: DW]   = v ? ma[i][idx] : DW'($urandom);
            weight_in[i*DW +: DW] = v ? mb[idx][i] : DW'($urandom);
        end
    endtask

    task automatic run_job(input int k, input bit sm, input int gap_pct, input int stall_pct,
                           input bit poke_start, input string tag);
        logic [AW-1:0] exp_c [N][N];
        logic [AW-1:0] hold_d;
        logic [IW-1:0] hold_r, hold_c;
        int idx, cyc, beats;
        bit hs, held;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) exp_c[r][c] = ref_c(r, c, k, sm);
        @(negedge clk);
        start = 1'b1; k_len = KW'(k); signed_mode = sm;
        @(negedge clk);
        start = 1'b0; k_len = KW'($urandom); signed_mode = 1'($urandom);
        check({tag, "_busy"}, 64'(busy), 64'(1));
        idx = 0; cyc = 0;
        while (idx < k && cyc < 1000) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            drive_vec(idx, in_valid);
            hs = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            if (hs) idx++;
        end
        check({tag, "_loaded"}, 64'(idx), 64'(k));
        in_valid = 1'b1;
        drive_vec(0, 1'b0);
        beats = 0; cyc = 0; held = 0; out_ready = 1'b0;
        while (beats < N*N && cyc < 2000) begin
            if (held) begin
                check({tag, "_stall_valid"}, 64'(out_valid), 64'(1));
                check({tag, "_stall_data"}, 64'(out_data), 64'(hold_d));
                check({tag, "_stall_idx"}, 64'({out_row, out_col}), 64'({hold_r, hold_c}));
                held = 0;
            end
            if (stall_pct == 0 && beats > 0)
                check({tag, "_no_bubble"}, 64'(out_valid), 64'(1));
            if (out_valid) begin
                start = (poke_start && beats == 1);
                out_ready = ($urandom_range(99) >= stall_pct);
                if (out_ready) begin
                    check({tag, "_data"}, 64'(out_data), 64'(exp_c[beats / N][beats % N]));
                    check({tag, "_row"}, 64'(out_row), 64'(beats / N));
                    check({tag, "_col"}, 64'(out_col), 64'(beats % N));
                    beats++;
                end else begin
                    held = 1; hold_d = out_data; hold_r = out_row; hold_c = out_col;
                end
            end else begin
                start = 1'b0;
                out_ready = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        check({tag, "_beats"}, 64'(beats), 64'(N*N));
        check({tag, "_done"}, 64'(done), 64'(1));
        check({tag, "_valid_low"}, 64'(out_valid), 64'(0));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'(0));
        check({tag, "_idle"}, 64'(busy), 64'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; k_len = '0; signed_mode = 1'b0; in_valid = 1'b0;
        data_in = '0; weight_in = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", 64'({in_ready, out_valid, busy, done}), 64'(0));
        check("rst_data", 64'({out_data, out_row, out_col}), 64'(0));
        rst = 1'b0;

        fill_const(8'd1, 8'd2);
        run_job(4, 1'b0, 0, 0, 1'b0, "ones");

        fill_const(8'hFD, 8'h02);
        run_job(1, 1'b1, 0, 0, 1'b0, "neg_signed");
        run_job(1, 1'b0, 0, 0, 1'b0, "neg_unsigned");

        fill_identity();
        run_job(4, 1'b0, 0, 0, 1'b0, "ident");
        run_job(4, 1'b0, 30, 40, 1'b0, "ident_stall");

        fill_rand();
        run_job(0, 1'b0, 0, 20, 1'b1, "k_zero");

        fill_rand();
        @(negedge clk);
        start = 1'b1; k_len = KW'(4); signed_mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        drive_vec(0, 1'b1);
        @(negedge clk);
        drive_vec(1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", 64'({in_ready, out_valid, busy, done}), 64'(0));
        check("abort_data", 64'({out_data, out_row, out_col}), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_no_beat", 64'({out_valid, done, busy}), 64'(0));
        fill_const(8'd3, 8'd5);
        run_job(1, 1'b0, 0, 0, 1'b0, "after_rst");

        for (int n = 0; n < 4; n++) begin
            fill_rand();
            run_job($urandom_range(KMAX, 1), 1'($urandom), 25, 35, 1'b0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
